// File: rtl/instruction_fetch_module.sv
// ---------------------------------------------------------------------------
// instruction_fetch_module
//
// Instruction fetch stage of the pipelined RISC. Owns the program counter,
// talks to instruction memory over a req/ack handshake and loads the IF/DOF
// pipeline register (PC_1, IR, IR_valid) consumed by decoder_fetch_module.
//
// Ports:
//   CLK        in   clock, rising-edge active
//   reset      in   asynchronous active-low reset
//   stall      in   hazard stall from DOF; IF/DOF register holds
//   MC         in   next-PC select: 00 seq, 01 BrA, 10 RAA, 11 seq
//   BrA        in   branch target
//   RAA        in   jump-register target
//   imem_req   out  instruction memory request
//   imem_addr  out  request address (stable until ack)
//   imem_ack   in   memory response, imem_rdata valid same cycle
//   imem_rdata in   fetched instruction
//   PC_1       out  fetched instruction address + 1
//   IR         out  fetched instruction (NOP for bubbles)
//   IR_valid   out  IR holds a real instruction
// ---------------------------------------------------------------------------
module instruction_fetch_module #(
  parameter int unsigned           PC_WIDTH = 16,
  parameter int unsigned           IR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0,
  parameter logic [IR_WIDTH-1:0]   NOP      = '0
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                stall,
  input  logic [1:0]          MC,
  input  logic [PC_WIDTH-1:0] BrA,
  input  logic [PC_WIDTH-1:0] RAA,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [IR_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0] PC_1,
  output logic [IR_WIDTH-1:0] IR,
  output logic                IR_valid
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] tgt_q, tgt_d;
  logic [IR_WIDTH-1:0] buf_q, buf_d;
  logic [PC_WIDTH-1:0] buf_pc_q, buf_pc_d;
  logic [PC_WIDTH-1:0] pc1_q, pc1_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                irv_q, irv_d;

  logic                redirect;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] pc_inc;

  assign redirect = (MC == 2'b01) || (MC == 2'b10);
  assign target   = MC[0] ? BrA : RAA;
  assign pc_inc   = pc_q + PC_WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    buf_d    = buf_q;
    buf_pc_d = buf_pc_q;
    pc1_d    = pc1_q;
    ir_d     = ir_q;
    irv_d    = irv_q;
    imem_req = 1'b0;

    // Flush beats stall: every redirect cycle forces a bubble into IF/DOF.
    if (redirect) begin
      ir_d  = NOP;
      irv_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) pc_d = target;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          if (imem_ack) begin
            pc_d = target;
          end else begin
            // The outstanding request must complete before the redirect.
            tgt_d   = target;
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          pc_d = pc_inc;
          if (stall) begin
            buf_d    = imem_rdata;
            buf_pc_d = pc_q;
            state_d  = HOLD;
          end else begin
            ir_d  = imem_rdata;
            pc1_d = pc_inc;
            irv_d = 1'b1;
          end
        end else if (!stall) begin
          ir_d  = NOP;
          irv_d = 1'b0;
        end
      end

      DRAIN: begin
        imem_req = 1'b1;
        if (!stall) begin
          ir_d  = NOP;
          irv_d = 1'b0;
        end
        // A redirect arriving in the ack cycle itself is the latest one.
        if (redirect) tgt_d = target;
        if (imem_ack) begin
          pc_d    = redirect ? target : tgt_q;
          state_d = FETCH;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall) begin
          ir_d    = buf_q;
          pc1_d   = buf_pc_q + PC_WIDTH'(1);
          irv_d   = 1'b1;
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      tgt_q    <= '0;
      buf_q    <= NOP;
      buf_pc_q <= '0;
      pc1_q    <= '0;
      ir_q     <= NOP;
      irv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      buf_q    <= buf_d;
      buf_pc_q <= buf_pc_d;
      pc1_q    <= pc1_d;
      ir_q     <= ir_d;
      irv_q    <= irv_d;
    end
  end

  assign imem_addr = pc_q;
  assign PC_1      = pc1_q;
  assign IR        = ir_q;
  assign IR_valid  = irv_q;

  a_addr_stable: assert property (
    @(posedge CLK) disable iff (!reset)
    (imem_req && !imem_ack) |=> $stable(imem_addr)
  );

endmodule

// File: tb/tb_instruction_fetch_module.sv
module tb_instruction_fetch_module;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        reset, stall;
  logic [1:0]  MC;
  logic [15:0] BrA, RAA;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, PC_1;
  logic [31:0] imem_rdata, IR;
  logic        IR_valid;

  // Second instance exercising a non-zero reset PC at the wrap point.
  logic        req2, irv2;
  logic [15:0] addr2, pc1_2;
  logic [31:0] rdata2, ir2;
  logic        stall2 = 1'b0;
  logic [1:0]  mc2 = 2'b00;
  logic [15:0] bra2 = 16'h0000, raa2 = 16'h0000;

  int wait_n;
  int wcnt;

  instruction_fetch_module dut (
    .CLK(CLK), .reset(reset), .stall(stall), .MC(MC), .BrA(BrA), .RAA(RAA),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .PC_1(PC_1), .IR(IR), .IR_valid(IR_valid)
  );

  instruction_fetch_module #(.RESET_PC(16'hFFFF)) dut2 (
    .CLK(CLK), .reset(reset), .stall(stall2), .MC(mc2), .BrA(bra2), .RAA(raa2),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(req2),
    .imem_rdata(rdata2), .PC_1(pc1_2), .IR(ir2), .IR_valid(irv2)
  );

  // Memory model: instruction word = address, acks after wait_n wait cycles.
  assign imem_ack   = imem_req && (wcnt >= wait_n);
  assign imem_rdata = imem_ack ? {16'h0000, imem_addr} : 32'hDEAD_BEEF;
  assign rdata2     = {16'h0000, addr2};

  always @(posedge CLK or negedge reset) begin
    if (!reset)                      wcnt <= 0;
    else if (imem_req && !imem_ack)  wcnt <= wcnt + 1;
    else                             wcnt <= 0;
  end

  typedef struct packed {
    logic [15:0] pc1;
    logic [31:0] ir;
  } exp_t;

  exp_t sbq[$];
  int checks   = 0;
  int failures = 0;
  int ndeliv   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] pc1, input logic [31:0] ir);
    exp_t e;
    e.pc1 = pc1;
    e.ir  = ir;
    sbq.push_back(e);
  endtask

  // One cycle of stimulus, applied at a falling edge.
  task automatic cyc(input bit s, input logic [1:0] mc, input logic [15:0] t);
    stall = s;
    MC    = mc;
    case (mc)
      2'b01:   begin BrA = t;        RAA = ~t;       end
      2'b10:   begin RAA = t;        BrA = ~t;       end
      default: begin BrA = 16'h0BAD; RAA = 16'h0BAE; end
    endcase
    @(negedge CLK);
  endtask

  // Monitor: a delivery is any edge that leaves IR_valid=1 with stall low.
  always begin : mon
    bit   st, rs;
    exp_t e;
    @(posedge CLK);
    st = stall;
    rs = reset;
    #1;
    if (rs && reset) begin
      if (IR_valid && !st) begin
        ndeliv++;
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_delivery actual IR=%h PC_1=%h required none", IR, PC_1);
        end else begin
          e = sbq.pop_front();
          chk("deliver_IR", IR, e.ir);
          chk("deliver_PC_1", {16'h0, PC_1}, {16'h0, e.pc1});
        end
      end else if (!IR_valid) begin
        chk("bubble_IR_is_NOP", IR, 32'h0);
      end
    end
  end

  initial begin : watchdog
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset = 1'b0; stall = 1'b0; MC = 2'b00; BrA = '0; RAA = '0; wait_n = 0;
    repeat (2) @(negedge CLK);
    chk("rst_req",      {31'h0, imem_req}, 32'h0);
    chk("rst_addr",     {16'h0, imem_addr}, 32'h0);
    chk("rst_IR",       IR, 32'h0);
    chk("rst_IR_valid", {31'h0, IR_valid}, 32'h0);
    chk("rst_PC_1",     {16'h0, PC_1}, 32'h0);
    chk("rst_addr2",    {16'h0, addr2}, 32'h0000_FFFF);

    reset = 1'b1;
    #1 chk("idle_req", {31'h0, imem_req}, 32'h0);
    cyc(0, 2'b00, 0);                                  // c1 IDLE
    chk("first_req",  {31'h0, imem_req}, 32'h1);
    chk("first_addr", {16'h0, imem_addr}, 32'h0);
    chk("wrap_addr2", {16'h0, addr2}, 32'h0000_FFFF);
    for (int i = 0; i < 5; i++) push(16'(i + 1), 32'(i));
    cyc(0, 2'b00, 0);                                  // c2 fetch 0
    chk("wrap_IR2_a",  ir2, 32'h0000_FFFF);
    chk("wrap_PC1_2a", {16'h0, pc1_2}, 32'h0);
    cyc(0, 2'b00, 0);                                  // c3 fetch 1
    chk("wrap_IR2_b",  ir2, 32'h0);
    chk("wrap_PC1_2b", {16'h0, pc1_2}, 32'h1);
    repeat (3) cyc(0, 2'b00, 0);                       // c4..c6
    chk("throughput", 32'(ndeliv), 32'd5);

    // Stall held 3 cycles while PC=5 is acked.
    push(16'd6, 32'd5);
    cyc(1, 2'b00, 0);                                  // c7
    chk("hold_req",      {31'h0, imem_req}, 32'h0);
    chk("hold_IR",       IR, 32'd4);
    chk("hold_PC_1",     {16'h0, PC_1}, 32'd5);
    chk("hold_IR_valid", {31'h0, IR_valid}, 32'h1);
    cyc(1, 2'b00, 0);                                  // c8
    cyc(1, 2'b00, 0);                                  // c9
    chk("hold_req_late", {31'h0, imem_req}, 32'h0);
    cyc(0, 2'b00, 0);                                  // c10 release
    chk("resume_addr", {16'h0, imem_addr}, 32'd6);
    push(16'd7, 32'd6);
    cyc(0, 2'b00, 0);                                  // c11

    // Two wait states.
    wait_n = 2;
    push(16'd8, 32'd7);
    cyc(0, 2'b00, 0);                                  // c12
    chk("w2_valid_0", {31'h0, IR_valid}, 32'h0);
    chk("w2_addr_0",  {16'h0, imem_addr}, 32'd7);
    cyc(0, 2'b00, 0);                                  // c13
    chk("w2_valid_1", {31'h0, IR_valid}, 32'h0);
    chk("w2_addr_1",  {16'h0, imem_addr}, 32'd7);
    cyc(0, 2'b00, 0);                                  // c14 ack
    chk("w2_valid_2", {31'h0, IR_valid}, 32'h1);
    push(16'd9, 32'd8);
    repeat (3) cyc(0, 2'b00, 0);                       // c15..c17

    // Branch while request to 9 is outstanding.
    cyc(0, 2'b00, 0);                                  // c18
    cyc(0, 2'b01, 16'h0040);                           // c19 redirect
    chk("drain_addr",  {16'h0, imem_addr}, 32'd9);
    chk("drain_req",   {31'h0, imem_req}, 32'h1);
    chk("drain_valid", {31'h0, IR_valid}, 32'h0);
    push(16'h0041, 32'h0040);
    cyc(0, 2'b00, 0);                                  // c20 drain ack
    chk("br_addr",  {16'h0, imem_addr}, 32'h0040);
    chk("br_valid", {31'h0, IR_valid}, 32'h0);
    repeat (3) cyc(0, 2'b00, 0);                       // c21..c23

    // Two redirects during one drain; the latest wins.
    wait_n = 4;
    push(16'h0021, 32'h0020);
    cyc(0, 2'b00, 0);                                  // c24
    cyc(0, 2'b10, 16'h0010);                           // c25
    chk("dd_addr_0", {16'h0, imem_addr}, 32'h0041);
    cyc(0, 2'b01, 16'h0020);                           // c26
    chk("dd_addr_1", {16'h0, imem_addr}, 32'h0041);
    cyc(0, 2'b00, 0);                                  // c27
    wait_n = 0;
    cyc(0, 2'b00, 0);                                  // c28 drain ack
    chk("dd_target", {16'h0, imem_addr}, 32'h0020);
    push(16'h0022, 32'h0021);
    cyc(0, 2'b00, 0);                                  // c29
    cyc(0, 2'b00, 0);                                  // c30

    // Redirect with stall high forces a bubble; target exercises PC wrap.
    cyc(1, 2'b10, 16'hFFFF);                           // c31
    chk("flush_IR",    IR, 32'h0);
    chk("flush_valid", {31'h0, IR_valid}, 32'h0);
    chk("flush_PC_1",  {16'h0, PC_1}, 32'h0022);
    chk("flush_addr",  {16'h0, imem_addr}, 32'h0000_FFFF);
    push(16'h0000, 32'h0000_FFFF);
    push(16'h0001, 32'h0000_0000);
    cyc(0, 2'b00, 0);                                  // c32
    cyc(0, 2'b00, 0);                                  // c33

    // Reset in the middle of a wait.
    wait_n = 3;
    cyc(0, 2'b00, 0);                                  // c34
    cyc(0, 2'b00, 0);                                  // c35
    chk("mid_req",  {31'h0, imem_req}, 32'h1);
    chk("mid_addr", {16'h0, imem_addr}, 32'h1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req",   {31'h0, imem_req}, 32'h0);
    chk("mid_rst_addr",  {16'h0, imem_addr}, 32'h0);
    chk("mid_rst_IR",    IR, 32'h0);
    chk("mid_rst_valid", {31'h0, IR_valid}, 32'h0);
    chk("mid_rst_PC_1",  {16'h0, PC_1}, 32'h0);
    chk("mid_rst_addr2", {16'h0, addr2}, 32'h0000_FFFF);
    chk("sb_empty",      32'(sbq.size()), 32'd0);
    chk("deliv_total",   32'(ndeliv), 32'd14);

    @(negedge CLK);
    reset = 1'b1;
    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_module.md
# instruction_fetch_module

Instruction fetch (IF) stage of the pipelined RISC. Holds the program counter, issues requests to instruction memory over a req/ack handshake, and loads the IF/DOF pipeline register (PC_1, IR, IR_valid) that feeds decoder_fetch_module. It applies next-PC selection (sequential, branch target BrA, register jump RAA), holds on pipeline stall, and flushes on redirect.

## Interface
- PC_WIDTH, 16, program counter and instruction memory address width
- IR_WIDTH, 32, instruction width
- RESET_PC, 16'h0000, first fetch address after reset
- NOP, 32'h0000_0000, instruction loaded into IR for bubbles and flushes
- CLK  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset; forces reset values immediately
- stall  in  1  hazard stall from DOF; IF/DOF register must hold
- MC  in  2  next-PC select: 00 sequential, 01 BrA, 10 RAA, 11 treated as 00
- BrA  in  PC_WIDTH  branch target from execute
- RAA  in  PC_WIDTH  jump-register target from execute
- imem_req  out  1  instruction memory request
- imem_addr  out  PC_WIDTH  request address; stable while imem_req is high and no ack
- imem_ack  in  1  memory response; imem_rdata valid in the same cycle
- imem_rdata  in  IR_WIDTH  fetched instruction
- PC_1  out  PC_WIDTH  fetched instruction address + 1, to DOF
- IR  out  IR_WIDTH  fetched instruction, to DOF
- IR_valid  out  1  IR holds a real instruction (0 = bubble)

## Operation
- State machine: IDLE, FETCH, DRAIN, HOLD. Registers: PC (outstanding/next address), tgt (pending redirect target), buf/buf_pc (skid entry).
- Redirect is MC of 01 or 10. The target is BrA or RAA.
- IDLE: imem_req=0. Goes to FETCH on the next edge.
- FETCH: imem_req=1, imem_addr=PC.
  - ack, no redirect, no stall: IR<=imem_rdata, PC_1<=PC+1, IR_valid<=1, PC<=PC+1. Stay in FETCH.
  - ack, no redirect, stall: IF/DOF register holds. buf<=imem_rdata, buf_pc<=PC, PC<=PC+1. Go to HOLD.
  - No ack, no redirect, no stall: IR<=NOP, IR_valid<=0, PC_1 holds.
  - No ack, no redirect, stall: everything holds.
  - Redirect with ack: response is dropped, PC<=target. Stay in FETCH.
  - Redirect without ack: tgt<=target. Go to DRAIN. An outstanding request is never abandoned.
- DRAIN: imem_req=1, imem_addr=PC (the old address).
  - On ack: data is dropped, PC<=tgt. Go to FETCH.
  - A further redirect in DRAIN overwrites tgt; the latest redirect wins.
- HOLD: imem_req=0.
  - stall deasserts: IR<=buf, PC_1<=buf_pc+1, IR_valid<=1. Go to FETCH.
  - Redirect: buf is discarded, PC<=target. Go to FETCH.
- Flush has priority over stall. Any redirect cycle loads IR<=NOP, IR_valid<=0, PC_1 unchanged, even while stall=1.
- Arithmetic: PC+1 is modulo 2^PC_WIDTH, so 16'hFFFF+1 = 16'h0000. No carry out.

## Timing
- Reset values: state=IDLE, PC=RESET_PC, tgt=0, buf=NOP, buf_pc=0, PC_1=0, IR=NOP, IR_valid=0, imem_req=0, imem_addr=RESET_PC.
- First imem_req assertion is in the second cycle after reset deasserts (one IDLE cycle).
- Fetch latency: ack in cycle N gives IR/IR_valid updated at the end of cycle N. With zero-wait memory (ack in the request cycle), throughput is 1 instruction per cycle.
- Redirect in cycle N with ack: target request is issued in N+1. Minimum 1 bubble cycle in IR.
- Redirect without ack: bubbles continue until the old ack drains; the target request follows on the cycle after that ack.
- Reset asserted mid-request: imem_req drops combinationally. Memory must tolerate an abandoned request. No redirect or skid state survives.
- imem_addr must not change while imem_req=1 and imem_ack=0 (checked by assertion).

## Test plan
- Reset, zero-wait memory returning instruction = address: after one IDLE cycle, IR sequence is 0,1,2,3, PC_1 sequence is 1,2,3,4, and IR_valid=1 every cycle.
- Memory with 2 wait states: IR_valid pattern is 0,0,1 repeating, and imem_addr is stable during each wait.
- stall held 3 cycles while ack arrives for PC=5: IR/PC_1 hold, state goes to HOLD with imem_req=0. On release, IR=inst@5 with PC_1=6, then fetch resumes at 6.
- MC=01, BrA=16'h0040, issued while a 2-wait request to PC=9 is outstanding: data for 9 is dropped, IR=NOP/IR_valid=0 during the drain, next imem_addr=16'h0040, and inst@0x40 is delivered with PC_1=16'h0041.
- Two redirects (RAA=16'h0010, then BrA=16'h0020) during DRAIN, and a redirect with stall=1: fetch goes to 16'h0020 only, and IR=NOP is forced despite stall.
- RESET_PC=16'hFFFF: fetches FFFF then 0000, PC_1 values 0000 then 0001. Reset asserted mid-wait: all outputs return to reset values immediately.
